// File: rtl/cache_refill_axi.sv
// cache_refill_axi: line-fill engine between the cache refill port and AXI4.
// On a cache miss it issues one INCR burst read for the whole line. Each
// returned beat is forwarded to the cache as a registered write with its byte
// address, and the final beat is flagged with mem_last.
// Optional feature macro: CACHE_REFILL_ERR_EN. When defined, the block records
// error responses and rlast mismatches, pulses refill_err with mem_last, and
// blanks the strobes of beats that carry an error response.
module cache_refill_axi #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_SIZE_BITS = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    // cache side
    input  logic                    miss,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic [DATA_WIDTH/8-1:0] mem_wstb,
    output logic                    mem_data_valid,
    output logic                    mem_last,
    output logic                    busy,
    output logic                    refill_err,
    // AXI4 read address channel
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int BEATS     = (2 ** LINE_SIZE_BITS) / BYTES;
    localparam int CNT_W     = $clog2(BEATS) + 1;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((2 ** LINE_SIZE_BITS) - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   line_base_q, line_base_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_data_q;
    logic [BYTES-1:0]        mem_wstb_q;
    logic                    mem_data_valid_q;
    logic                    mem_last_q;
    logic                    busy_q;
    logic                    refill_err_q;

    logic                    beat_accept;
    logic                    beat_last;
    logic [ADDR_WIDTH-1:0]   beat_off;
    logic [BYTES-1:0]        beat_wstb;
    logic                    refill_err_next;

    // The beat counter, not rlast, decides which beat closes the line.
    assign beat_accept = (state_q == DATA) && rvalid;
    assign beat_last   = beat_accept && (cnt_q == LAST_CNT);
    assign beat_off    = ADDR_WIDTH'(cnt_q) << SIZE_LOG2;

`ifdef CACHE_REFILL_ERR_EN
    logic err_q;
    logic beat_err;
    logic unused_inputs;

    // Any SLVERR/DECERR response, or an rlast that disagrees with our count.
    assign beat_err        = rresp[1] | (rlast != (cnt_q == LAST_CNT));
    assign beat_wstb       = rresp[1] ? '0 : '1;
    assign refill_err_next = beat_last & (err_q | beat_err);
    assign unused_inputs   = rresp[0];

    // Sticky error flag for the line being filled; cleared when a new miss is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && miss) begin
            err_q <= 1'b0;
        end else if (beat_accept) begin
            err_q <= err_q | beat_err;
        end
    end
`else
    logic unused_inputs;

    assign beat_wstb       = '1;
    assign refill_err_next = 1'b0;
    assign unused_inputs   = &{1'b0, rresp, rlast};
`endif

    // State, line base and beat counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            line_base_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic; a miss dropping during ADDR/DATA is ignored so the
    // burst always completes, and DONE waits for miss low to avoid retriggering.
    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    line_base_d = cpu_addr & ~OFFSET_MASK;
                    cnt_d       = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!miss) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered refill beat towards the cache plus the busy/error status.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q       <= '0;
            mem_data_q       <= '0;
            mem_wstb_q       <= '0;
            mem_data_valid_q <= 1'b0;
            mem_last_q       <= 1'b0;
            busy_q           <= 1'b0;
            refill_err_q     <= 1'b0;
        end else begin
            mem_data_valid_q <= beat_accept;
            mem_last_q       <= beat_last;
            refill_err_q     <= refill_err_next;
            busy_q           <= (state_d != IDLE);
            if (beat_accept) begin
                mem_addr_q <= line_base_q + beat_off;
                mem_data_q <= rdata;
                mem_wstb_q <= beat_wstb;
            end
        end
    end

    // AR fields are derived from registered state only, so they stay
    // constant for as long as arvalid is held.
    assign arvalid        = (state_q == ADDR);
    assign araddr         = line_base_q;
    assign arlen          = 8'(BEATS - 1);
    assign arsize         = 3'(SIZE_LOG2);
    assign arburst        = 2'b01;
    assign rready         = (state_q == DATA);

    assign mem_addr       = mem_addr_q;
    assign mem_data_out   = mem_data_q;
    assign mem_wstb       = mem_wstb_q;
    assign mem_data_valid = mem_data_valid_q;
    assign mem_last       = mem_last_q;
    assign busy           = busy_q;
    assign refill_err     = refill_err_q;

endmodule

// File: tb/tb_cache_refill_axi.sv
// Testbench for cache_refill_axi (default parameters: 32-bit data, 128-byte
// lines, 32 beats). Honours CACHE_REFILL_ERR_EN when defined on the command line.
module tb_cache_refill_axi;

    localparam int BEATS      = 32;
    localparam int LINE_BYTES = 128;
    localparam int BEAT_BYTES = 4;

`ifdef CACHE_REFILL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        miss;
    logic [31:0] cpu_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_wstb;
    logic        mem_data_valid;
    logic        mem_last;
    logic        busy;
    logic        refill_err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    cache_refill_axi dut (
        .clk            (clk),
        .reset          (reset),
        .miss           (miss),
        .cpu_addr       (cpu_addr),
        .mem_addr       (mem_addr),
        .mem_data_out   (mem_data_out),
        .mem_wstb       (mem_wstb),
        .mem_data_valid (mem_data_valid),
        .mem_last       (mem_last),
        .busy           (busy),
        .refill_err     (refill_err),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete refill. Expected beats come from the line arithmetic:
    // base = addr rounded down to the line, beat i at base + 4*i.
    task automatic run_refill(input logic [31:0] addr, input int ar_delay, input int vmode,
                              input int err_beat, input int bad_rlast, input int hold,
                              input bit data_idx, input int abort_after);
        logic [31:0] base;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        bit          v, lst, err_seen, exp_err;
        int          sent, cyc;
        base     = addr - (addr % LINE_BYTES);
        err_seen = 1'b0;
        sent     = 0;
        cyc      = 0;
        miss     = 1'b1;
        cpu_addr = addr;
        step();
        for (int i = 0; i <= ar_delay; i++) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== base) begin
                errors++;
                $display("FAIL ar_phase cyc=%0d got arvalid=%0b araddr=%h exp arvalid=1 araddr=%h", i, arvalid, araddr, base);
            end
            checks++;
            if (rready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ar_wait cyc=%0d got rready=%0b busy=%0b exp rready=0 busy=1", i, rready, busy);
            end
            checks++;
            if (arlen !== 8'd31 || arsize !== 3'd2 || arburst !== 2'b01) begin
                errors++;
                $display("FAIL ar_fields got len=%0d size=%0d burst=%0d exp 31 2 1", arlen, arsize, arburst);
            end
            arready = (i == ar_delay);
            step();
        end
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_handshake got rready=%0b arvalid=%0b exp rready=1 arvalid=0", rready, arvalid);
        end
        while (sent < BEATS && cyc < 1000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 99) < 65);
            endcase
            cyc++;
            lst      = (sent == BEATS - 1);
            exp_data = data_idx ? 32'(sent) : $urandom;
            rvalid   = v;
            rdata    = v ? exp_data : $urandom;
            rresp    = {v && (sent == err_beat), 1'($urandom_range(0, 1))};
            rlast    = v ? (lst ^ (sent == bad_rlast)) : 1'($urandom_range(0, 1));
            exp_strb = (ERR_EN && rresp[1]) ? 4'h0 : 4'hF;
            if (v) err_seen = err_seen | rresp[1] | (rlast != lst);
            exp_err  = ERR_EN && v && lst && err_seen;
            step();
            checks++;
            if (mem_data_valid !== v) begin
                errors++;
                $display("FAIL beat_valid beat=%0d got=%0b exp=%0b", sent, mem_data_valid, v);
            end
            checks++;
            if (mem_last !== (v && lst)) begin
                errors++;
                $display("FAIL beat_last beat=%0d got=%0b exp=%0b", sent, mem_last, v && lst);
            end
            checks++;
            if (refill_err !== exp_err) begin
                errors++;
                $display("FAIL refill_err beat=%0d got=%0b exp=%0b", sent, refill_err, exp_err);
            end
            if (v) begin
                checks++;
                if (mem_addr !== base + 32'(sent * BEAT_BYTES)) begin
                    errors++;
                    $display("FAIL beat_addr beat=%0d got=%h exp=%h", sent, mem_addr, base + 32'(sent * BEAT_BYTES));
                end
                checks++;
                if (mem_data_out !== exp_data) begin
                    errors++;
                    $display("FAIL beat_data beat=%0d got=%h exp=%h", sent, mem_data_out, exp_data);
                end
                checks++;
                if (mem_wstb !== exp_strb) begin
                    errors++;
                    $display("FAIL beat_wstb beat=%0d got=%h exp=%h", sent, mem_wstb, exp_strb);
                end
                sent++;
            end
            if (abort_after >= 0 && sent == abort_after) begin
                rvalid = 1'b0;
                $display("refill addr=%h base=%h aborted after %0d beats", addr, base, sent);
                return;
            end
        end
        rvalid = 1'b0;
        checks++;
        if (sent != BEATS) begin
            errors++;
            $display("FAIL beat_timeout got=%0d beats exp=%0d", sent, BEATS);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            checks++;
            if (arvalid !== 1'b0 || busy !== 1'b1 || mem_data_valid !== 1'b0 || rready !== 1'b0) begin
                errors++;
                $display("FAIL done_hold cyc=%0d got arvalid=%0b busy=%0b valid=%0b rready=%0b exp 0 1 0 0",
                         i, arvalid, busy, mem_data_valid, rready);
            end
        end
        miss = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop got busy=%0b arvalid=%0b exp busy=0 arvalid=0", busy, arvalid);
        end
        $display("refill addr=%h base=%h beats=%0d cycles=%0d err=%0b", addr, base, sent, cyc, err_seen);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || mem_data_valid !== 1'b0 || mem_last !== 1'b0 ||
            busy !== 1'b0 || refill_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctrl got arvalid=%0b rready=%0b valid=%0b last=%0b busy=%0b err=%0b exp all 0",
                     tag, arvalid, rready, mem_data_valid, mem_last, busy, refill_err);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_data_out !== 32'h0 || mem_wstb !== 4'h0) begin
            errors++;
            $display("FAIL %s_data got addr=%h data=%h wstb=%h exp 0 0 0", tag, mem_addr, mem_data_out, mem_wstb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check_reset_outputs("idle");
        $display("test_reset done");
    endtask

    task automatic test_directed_line();
        run_refill(32'h0000_12B4, 0, 0, -1, -1, 0, 1'b1, -1);
    endtask

    task automatic test_arready_stall();
        run_refill(32'h8000_0044, 4, 0, -1, -1, 0, 1'b0, -1);
    endtask

    task automatic test_rvalid_toggle();
        run_refill(32'h0000_0F7C, 1, 1, -1, -1, 0, 1'b0, -1);
    endtask

    task automatic test_miss_hold();
        run_refill(32'h0004_0200, 0, 0, -1, -1, 3, 1'b0, -1);
    endtask

    task automatic test_error_beat();
        run_refill(32'h0000_12B4, 0, 0, 7, -1, 1, 1'b1, -1);
    endtask

    task automatic test_rlast_mismatch();
        run_refill(32'h0000_3300, 2, 0, -1, 3, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_data();
        run_refill(32'h0000_5A10, 0, 0, -1, -1, 0, 1'b1, 5);
        reset = 1'b1;
        miss  = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        run_refill(32'h0000_7788, 1, 0, -1, -1, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_refill($urandom, $urandom_range(0, 3), 2,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1,
                       $urandom_range(0, 3), 1'b0, -1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        miss     = 1'b0;
        cpu_addr = '0;
        arready  = 1'b0;
        rdata    = '0;
        rresp    = '0;
        rlast    = 1'b0;
        rvalid   = 1'b0;
        test_reset();
        test_directed_line();
        test_arready_stall();
        test_rvalid_toggle();
        test_miss_hold();
        test_error_beat();
        test_rlast_mismatch();
        test_reset_mid_data();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
